// File: rtl/teclado_ps2_pkg.sv
// teclado_ps2_pkg: scan-code/ASCII constants, receiver state encoding and make-code translation
// Ports: none (package)
package teclado_ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} estado_t;
  localparam logic [7:0] SC_W = 8'h1D, SC_S = 8'h1B, SC_A = 8'h1C, SC_D = 8'h23;
  localparam logic [7:0] SC_I = 8'h43, SC_RST = 8'h2D, SC_P = 8'h4D;
  localparam logic [7:0] SC_BREAK = 8'hF0, SC_EXT = 8'hE0;
  localparam logic [7:0] ASC_W = 8'h57, ASC_S = 8'h53, ASC_A = 8'h41, ASC_D = 8'h44;
  localparam logic [7:0] ASC_I = 8'h49, ASC_RST = 8'h08, ASC_P = 8'h50;
  // {valid, ascii}; valid=0 for any code that is not a known make code
  function automatic logic [8:0] traducir(input logic [7:0] sc);
    traducir = sc == SC_W   ? {1'b1, ASC_W}   :
               sc == SC_S   ? {1'b1, ASC_S}   :
               sc == SC_A   ? {1'b1, ASC_A}   :
               sc == SC_D   ? {1'b1, ASC_D}   :
               sc == SC_I   ? {1'b1, ASC_I}   :
               sc == SC_RST ? {1'b1, ASC_RST} :
               sc == SC_P   ? {1'b1, ASC_P}   : 9'h000;
  endfunction
endpackage

// File: rtl/ps2_rx_trama.sv
// ps2_rx_trama: PS/2 synchronizer, clock filter and 11-bit frame receiver with parity/stop/timeout checks
// Ports: clk, reset, i_ps2c, i_ps2d in; o_byte[7:0], o_byte_ok (pulse on stop edge), o_error_trama (pulse), o_ocupado out
module ps2_rx_trama
  import teclado_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2c,
  input  logic       i_ps2d,
  output logic [7:0] o_byte,
  output logic       o_byte_ok,
  output logic       o_error_trama,
  output logic       o_ocupado
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] r_c_sync, r_d_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic r_fc, r_fc_q, r_par, r_err;
  logic [2:0] r_cnt;
  logic [7:0] r_data;
  logic [TW-1:0] r_tmo;
  estado_t r_state;
  logic w_fall, w_d, w_par_ok, w_timeout;
  assign w_fall    = r_fc_q & ~r_fc;
  assign w_d       = r_d_sync[1];
  assign w_par_ok  = ^{r_data, r_par};
  assign w_timeout = r_state != IDLE && !w_fall && r_tmo == TW'(TIMEOUT_CYC - 1);
  // combinational so the key register can load on the cycle right after the stop edge
  assign o_byte_ok     = w_fall && r_state == PARADA && w_d && w_par_ok;
  assign o_byte        = r_data;
  assign o_error_trama = r_err;
  assign o_ocupado     = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
      r_filt   <= '1;
      r_fc     <= 1'b1;
      r_fc_q   <= 1'b1;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c};
      r_d_sync <= {r_d_sync[0], i_ps2d};
      r_filt   <= {r_filt[FILTER_LEN-2:0], r_c_sync[1]};
      r_fc     <= &r_filt ? 1'b1 : ~|r_filt ? 1'b0 : r_fc;
      r_fc_q   <= r_fc;
      r_err    <= 1'b0;
      r_tmo    <= (w_fall || r_state == IDLE) ? '0 : r_tmo + 1'b1;
      if (w_timeout) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            r_state <= w_d ? IDLE : DATOS;
            r_cnt   <= '0;
          end
          DATOS: begin
            r_data  <= {w_d, r_data[7:1]};
            r_cnt   <= r_cnt + 1'b1;
            r_state <= r_cnt == 3'd7 ? PARIDAD : DATOS;
          end
          PARIDAD: begin
            r_par   <= w_d;
            r_state <= PARADA;
          end
          default: begin
            r_state <= IDLE;
            r_err   <= !(w_d && w_par_ok);
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/teclado_ps2.sv
// teclado_ps2: PS/2 keyboard to processor interface; decodes make/break codes and holds one pending key
// Ports: clk, reset, ps2c, ps2d, interrupt_ack in; tecla[7:0], interrupt, error_trama, ocupado out
module teclado_ps2
  import teclado_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       interrupt_ack,
  output logic [7:0] tecla,
  output logic       interrupt,
  output logic       error_trama,
  output logic       ocupado
);
  logic [7:0] w_byte;
  logic w_byte_ok, w_load;
  logic [8:0] w_tr;
  logic r_brk, r_int;
  logic [7:0] r_tecla;
  ps2_rx_trama #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .reset(reset), .i_ps2c(ps2c), .i_ps2d(ps2d),
    .o_byte(w_byte), .o_byte_ok(w_byte_ok), .o_error_trama(error_trama), .o_ocupado(ocupado)
  );
  assign w_tr = traducir(w_byte);
  // an ack in the same cycle always wins over a newly arriving key
  assign w_load = w_byte_ok && !r_brk && w_tr[8] && !r_int && !interrupt_ack;
  assign tecla = r_tecla;
  assign interrupt = r_int;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_brk   <= 1'b0;
      r_int   <= 1'b0;
      r_tecla <= '0;
    end else begin
      if (w_byte_ok && w_byte == SC_BREAK) r_brk <= 1'b1;
      else if (w_byte_ok && w_byte != SC_EXT) r_brk <= 1'b0;
      if (w_load) begin
        r_tecla <= w_tr[7:0];
        r_int   <= 1'b1;
      end else if (interrupt_ack) r_int <= 1'b0;
    end
  end
endmodule

// File: tb/tb_teclado_ps2.sv
// tb_teclado_ps2: scoreboard bench driving PS/2 frames against a behavioural keyboard model
module tb_teclado_ps2;
  localparam int FL = 8, TO = 400;
  logic clk = 0, reset = 1, ps2c = 1, ps2d = 1, interrupt_ack = 0;
  logic [7:0] tecla;
  logic interrupt, error_trama, ocupado;
  int cyc = 0, errors = 0, checks = 0, last_fall = 0;
  typedef struct {bit is_err; logic [7:0] val; int lo; int hi;} ev_t;
  ev_t q[$];
  bit m_pend = 0, m_brk = 0;
  logic [7:0] m_key = 8'h00;

  teclado_ps2 #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .interrupt_ack(interrupt_ack),
    .tecla(tecla), .interrupt(interrupt), .error_trama(error_trama), .ocupado(ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [8:0] ref_ascii(input logic [7:0] sc);
    case (sc)
      8'h1D: return {1'b1, 8'h57};
      8'h1B: return {1'b1, 8'h53};
      8'h1C: return {1'b1, 8'h41};
      8'h23: return {1'b1, 8'h44};
      8'h43: return {1'b1, 8'h49};
      8'h2D: return {1'b1, 8'h08};
      8'h4D: return {1'b1, 8'h50};
      default: return 9'h000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit drop);
    logic [8:0] r;
    ev_t e;
    r = ref_ascii(b);
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_brk = m_brk;
    else if (m_brk) m_brk = 0;
    else if (r[8] && !m_pend && !drop) begin
      m_pend = 1;
      m_key = r[7:0];
      e.is_err = 0; e.val = r[7:0]; e.lo = 0; e.hi = 0;
      q.push_back(e);
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch, input bit ack_here);
    ps2d = b;
    if (glitch) begin
      w(3); ps2c = 0; w(3); ps2c = 1; w(4);
    end else w(10);
    ps2c = 0;
    last_fall = cyc;
    if (ack_here) interrupt_ack = 1;
    if (glitch) begin
      w(12); ps2c = 1; w(3); ps2c = 0; w(5);
    end else w(20);
    interrupt_ack = 0;
    ps2c = 1;
    w(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                            input bit glitch = 0, input int nbits = 11, input bit ack_stop = 0);
    logic [10:0] f;
    ev_t e;
    f = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
    if (nbits == 11) begin
      if (bad_par || bad_stop) begin
        e.is_err = 1; e.val = 0; e.lo = 0; e.hi = 0;
        q.push_back(e);
      end else begin
        if (ack_stop) m_pend = 0;
        model_byte(b, ack_stop);
      end
    end
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i == 3 || i == 6), ack_stop && i == 10);
    ps2d = 1;
    w(20);
  endtask

  task automatic do_ack();
    interrupt_ack = 1;
    w(1);
    interrupt_ack = 0;
    m_pend = 0;
    check("ack_int", interrupt, 0);
    check("ack_tecla", tecla, m_key);
  endtask

  task automatic check_state(input string name);
    check({name, "_int"}, interrupt, m_pend);
    check({name, "_tecla"}, tecla, m_key);
  endtask

  initial begin : monitor
    bit p_int, p_ocup, p_err;
    ev_t e;
    p_int = 0; p_ocup = 0; p_err = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (p_err) check("err_pulse_width", error_trama, 0);
        if ((interrupt && !p_int) || (error_trama && !p_err)) begin
          if (q.size() == 0) check("unexpected_event", {interrupt, error_trama}, 0);
          else begin
            e = q.pop_front();
            if (error_trama && !p_err) begin
              check("event_is_err", e.is_err, 1);
              if (e.lo != 0) check("timeout_window", cyc >= e.lo && cyc <= e.hi, 1);
            end else begin
              check("event_is_key", e.is_err, 0);
              check("key_value", tecla, e.val);
              check("key_latency", {p_ocup, ocupado}, 2'b10);
            end
          end
        end
      end
      p_int = interrupt; p_ocup = ocupado; p_err = error_trama;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] codes [10];
    ev_t e;
    codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h2D, 8'h4D, 8'hF0, 8'hE0, 8'h00};
    w(3);
    reset = 0;
    w(30);
    check("rst_tecla", tecla, 8'h00);
    check("rst_int", interrupt, 0);
    check("rst_err", error_trama, 0);
    check("rst_ocupado", ocupado, 0);
    send_frame(8'h1D);
    check_state("w_key");
    do_ack();
    send_frame(8'h1C);
    do_ack();
    send_frame(8'hF0);
    send_frame(8'h1C);
    check_state("break");
    send_frame(8'h23, 1);
    check_state("bad_parity");
    send_frame(8'h43, 0, 0, 0, 4);
    check("busy_partial", ocupado, 1);
    e.is_err = 1; e.val = 0; e.lo = last_fall + TO; e.hi = last_fall + TO + FL + 8;
    q.push_back(e);
    w(TO + 40);
    check("timeout_idle", ocupado, 0);
    check("timeout_drained", q.size(), 0);
    send_frame(8'h43);
    check_state("after_timeout");
    do_ack();
    send_frame(8'h2D);
    send_frame(8'h4D);
    check_state("hold_pending");
    send_frame(8'h4D, 0, 0, 0, 11, 1);
    check_state("ack_wins");
    send_frame(8'hE0);
    send_frame(8'h1D);
    check_state("ext_prefix");
    do_ack();
    send_frame(8'hF0);
    send_frame(8'hE0);
    send_frame(8'h1B);
    send_frame(8'h1B);
    check_state("break_ext");
    do_ack();
    send_frame(8'h1D, 0, 0, 1);
    check_state("glitch");
    do_ack();
    send_frame(8'h1C, 0, 1);
    check_state("bad_stop");
    send_frame(8'h1D, 0, 0, 0, 5);
    check("busy_mid", ocupado, 1);
    reset = 1;
    w(2);
    reset = 0;
    m_pend = 0; m_brk = 0; m_key = 8'h00;
    w(1);
    check("rst_mid_ocupado", ocupado, 0);
    check_state("rst_mid");
    w(TO + 40);
    check("rst_mid_quiet", error_trama, 0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int k;
      k = $urandom_range(0, 9);
      b = k == 9 ? 8'($urandom) : codes[k];
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_ack();
      check_state("rand");
    end
    w(50);
    check("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
